// File: rtl/pp_pipeline_accel_pkg.sv
// pp_pipeline_accel_pkg: shared types and widths for the pre-processing pipeline.
// Contents: unpack FSM state type, unpacker word/pixel/buffer widths.
package pp_pipeline_accel_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} unpack_state_t;
    localparam int UNPACK_WORD_W = 64;
    localparam int UNPACK_PIX_W  = 24;
    localparam int UNPACK_BUF_W  = 88;
    localparam int UNPACK_BCNT_W = 7;
endpackage

// File: rtl/pp_pipeline_accel_unpack_buf.sv
// pp_pipeline_accel_unpack_buf: 88-bit residue buffer with pixel shift-out and word merge.
// Ports: clk, reset (sync, active-high), clear (drop contents), emit (shift out one pixel),
//        load (merge data above the post-emit residue), data (input word),
//        pix (lowest pixel of the buffer), bit_cnt (valid bits held).
module pp_pipeline_accel_unpack_buf
    import pp_pipeline_accel_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     emit,
    input  logic                     load,
    input  logic [UNPACK_WORD_W-1:0] data,
    output logic [UNPACK_PIX_W-1:0]  pix,
    output logic [UNPACK_BCNT_W-1:0] bit_cnt
);
    logic [UNPACK_BUF_W-1:0]  r_buf;
    logic [UNPACK_BUF_W-1:0]  w_shift;
    logic [UNPACK_BCNT_W-1:0] r_bit_cnt;
    logic [UNPACK_BCNT_W-1:0] w_cnt;

    // A merge lands on top of whatever is left after this cycle's emit.
    assign w_shift = emit ? r_buf >> UNPACK_PIX_W : r_buf;
    assign w_cnt   = emit ? r_bit_cnt - UNPACK_BCNT_W'(UNPACK_PIX_W) : r_bit_cnt;
    assign pix     = r_buf[UNPACK_PIX_W-1:0];
    assign bit_cnt = r_bit_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_buf     <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_buf     <= load ? w_shift | (UNPACK_BUF_W'(data) << w_cnt) : w_shift;
            r_bit_cnt <= load ? w_cnt + UNPACK_BCNT_W'(UNPACK_WORD_W) : w_cnt;
        end
    end
endmodule

// File: rtl/pp_pipeline_accel_unpack_64to24.sv
// pp_pipeline_accel_unpack_64to24: 64-bit word stream to packed 24-bit pixel FIFO writer.
// Ports: clk, reset (sync, active-high); start/frame_pixels (frame launch, sampled in IDLE);
//        in_valid/in_ready/in_data (word stream); out_write/out_din/out_full_n (FIFO write port);
//        busy (in RUN), done (frame-end pulse), stall_cnt (full-stall count).
// Option: define PP_UNPACK_STATS_EN to build the saturating stall counter; otherwise stall_cnt is 0.
module pp_pipeline_accel_unpack_64to24
    import pp_pipeline_accel_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int PIX_W  = 24,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  frame_pixels,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_write,
    output logic [PIX_W-1:0]  out_din,
    input  logic              out_full_n,
    output logic              busy,
    output logic              done,
    output logic [31:0]       stall_cnt
);
    unpack_state_t            r_state;
    unpack_state_t            w_next;
    logic [CNT_W-1:0]         r_pix_left;
    logic [22:0]              r_words_left;
    logic [UNPACK_BCNT_W-1:0] w_bit_cnt;
    logic                     w_have_pix;
    logic                     w_emit;
    logic                     w_accept;
    logic                     w_start;

    pp_pipeline_accel_unpack_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .clear   (r_state != ST_RUN),
        .emit    (w_emit),
        .load    (w_accept),
        .data    (in_data),
        .pix     (out_din),
        .bit_cnt (w_bit_cnt)
    );

    assign w_have_pix = (r_state == ST_RUN) && (w_bit_cnt >= 7'd24) && (r_pix_left != '0);
    assign w_emit     = w_have_pix && out_full_n;
    // Refill when the residue is below one pixel, or when this cycle's emit drops it there.
    assign in_ready   = (r_state == ST_RUN) && (r_words_left != '0) &&
                        ((w_bit_cnt <= 7'd23) || (w_emit && w_bit_cnt <= 7'd47));
    assign w_accept   = in_valid && in_ready;
    assign w_start    = (r_state == ST_IDLE) && start;
    assign out_write  = w_emit;
    assign busy       = r_state == ST_RUN;
    assign done       = r_state == ST_DONE;

    always_comb begin
        w_next = r_state;
        w_next = (r_state == ST_IDLE) ? (start ? ((frame_pixels == '0) ? ST_DONE : ST_RUN) : ST_IDLE) :
                 (r_state == ST_RUN)  ? ((w_emit && r_pix_left == CNT_W'(1)) ? ST_DONE : ST_RUN) :
                                        ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pix_left   <= '0;
            r_words_left <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_pix_left   <= frame_pixels;
                // Word count rounds 24*n bits up to whole words; 27 bits avoids overflow.
                r_words_left <= 23'((27'(frame_pixels) * 27'd3 + 27'd7) >> 3);
            end else begin
                if (w_emit)   r_pix_left   <= r_pix_left - CNT_W'(1);
                if (w_accept) r_words_left <= r_words_left - 23'd1;
            end
        end
    end

`ifdef PP_UNPACK_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset || w_start)
            r_stall_cnt <= '0;
        else if (w_have_pix && !out_full_n && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pp_pipeline_accel_unpack_64to24.sv
// tb_pp_pipeline_accel_unpack_64to24: directed self-checking bench for the 64-to-24 unpacker.
module tb_pp_pipeline_accel_unpack_64to24;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] frame_pixels;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_write;
    logic [23:0] out_din;
    logic        out_full_n;
    logic        busy;
    logic        done;
    logic [31:0] stall_cnt;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          nwr, ndone, widx, nwords, done_cyc, start_cyc;
    logic        feed, saw_ready;
    logic [63:0] mem [4];
    logic [23:0] got [16];
    int          wcyc [16];
    logic [23:0] exp_px [8];

    pp_pipeline_accel_unpack_64to24 dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .frame_pixels (frame_pixels),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_write    (out_write),
        .out_din      (out_din),
        .out_full_n   (out_full_n),
        .busy         (busy),
        .done         (done),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        in_valid = feed && widx < nwords;
        in_data  = (widx < 4) ? mem[widx] : 64'h0;
    endtask

    task automatic step();
        logic acc;
        #3;
        acc = in_valid && in_ready;
        if (out_write && nwr < 16) begin
            got[nwr]  = out_din;
            wcyc[nwr] = cyc;
            nwr++;
        end
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
        if (in_ready) saw_ready = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        if (acc) widx++;
        drive();
    endtask

    task automatic clr();
        nwr = 0;
        ndone = 0;
        widx = 0;
        saw_ready = 1'b0;
        done_cyc = -1;
    endtask

    task automatic load_stream();
        for (int w = 0; w < 3; w++)
            for (int b = 0; b < 8; b++)
                mem[w][8*b +: 8] = 8'(8*w + b);
        mem[3] = 64'h0;
        nwords = 3;
    endtask

    task automatic start_frame(input logic [23:0] n);
        start = 1'b1;
        frame_pixels = n;
        start_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        for (int i = 0; i < lim && ndone == 0; i++) step();
        check(tag, 64'(ndone), 64'd1);
    endtask

    task automatic check_pixels(input string tag);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_px%0d", tag, i), 64'(got[i]), 64'(exp_px[i]));
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            exp_px[i] = {8'(3*i + 2), 8'(3*i + 1), 8'(3*i)};
        reset = 1'b1;
        start = 1'b0;
        frame_pixels = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_full_n = 1'b1;
        feed = 1'b0;
        nwords = 0;
        mem[0] = '0; mem[1] = '0; mem[2] = '0; mem[3] = '0;
        clr();
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_write", 64'(out_write), 64'd0);
        check("rst_out_din", 64'(out_din), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);

        // 8 pixels at full rate
        load_stream();
        clr();
        feed = 1'b1;
        drive();
        start_frame(24'd8);
        wait_done("t1_done", 40);
        step();
        step();
        check("t1_nwr", 64'(nwr), 64'd8);
        check_pixels("t1");
        check("t1_first_lat", 64'(wcyc[0] - start_cyc), 64'd2);
        check("t1_back2back", 64'(wcyc[7] - wcyc[0]), 64'd7);
        check("t1_done_lat", 64'(done_cyc - wcyc[7]), 64'd1);
        check("t1_done_once", 64'(ndone), 64'd1);
        check("t1_words", 64'(widx), 64'd3);
        check("t1_busy", 64'(busy), 64'd0);

        // residual discard
        clr();
        mem[0] = 64'hA1A2_A3A4_A5A6_A7A8;
        mem[1] = 64'hB1B2_B3B4_B5B6_B7B8;
        mem[2] = 64'hC1C2_C3C4_C5C6_C7C8;
        nwords = 3;
        drive();
        start_frame(24'd3);
        wait_done("t2_done", 20);
        step();
        check("t2_nwr", 64'(nwr), 64'd3);
        check("t2_px0", 64'(got[0]), 64'hA6A7A8);
        check("t2_px1", 64'(got[1]), 64'hA3A4A5);
        check("t2_px2", 64'(got[2]), 64'hB8A1A2);
        check("t2_words", 64'(widx), 64'd2);
        check("t2_in_ready", 64'(in_ready), 64'd0);
        check("t2_residue", 64'(out_din), 64'd0);

        // back-pressure
        load_stream();
        clr();
        drive();
        start_frame(24'd8);
        step();
        step();
        step();
        check("t3_pre_nwr", 64'(nwr), 64'd2);
        out_full_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_stall_write", 64'(out_write), 64'd0);
            check("t3_stall_din", 64'(out_din), 64'h080706);
            step();
        end
        out_full_n = 1'b1;
        wait_done("t3_done", 40);
        check("t3_nwr", 64'(nwr), 64'd8);
        check_pixels("t3");
`ifdef PP_UNPACK_STATS_EN
        check("t3_stall_cnt", 64'(stall_cnt), 64'd5);
`else
        check("t3_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

        // empty frame
        clr();
        feed = 1'b0;
        drive();
        start_frame(24'd0);
        step();
        step();
        check("t4_done_lat", 64'(done_cyc - start_cyc), 64'd1);
        check("t4_done_once", 64'(ndone), 64'd1);
        check("t4_no_ready", 64'(saw_ready), 64'd0);
        check("t4_nwr", 64'(nwr), 64'd0);
        check("t4_stall_clr", 64'(stall_cnt), 64'd0);

        // mid-frame reset then a clean frame
        load_stream();
        clr();
        feed = 1'b1;
        drive();
        start_frame(24'd8);
        for (int i = 0; i < 20 && nwr < 4; i++) step();
        check("t5_pre_nwr", 64'(nwr), 64'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_in_ready", 64'(in_ready), 64'd0);
        check("t5_out_write", 64'(out_write), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        clr();
        drive();
        start_frame(24'd8);
        wait_done("t5_done", 40);
        check("t5_nwr", 64'(nwr), 64'd8);
        check_pixels("t5");
        check("t5_words", 64'(widx), 64'd3);

        // start pulsed while running
        clr();
        drive();
        start_frame(24'd8);
        step();
        step();
        start = 1'b1;
        frame_pixels = 24'd3;
        step();
        start = 1'b0;
        frame_pixels = 24'd0;
        wait_done("t6_done", 40);
        step();
        step();
        check("t6_nwr", 64'(nwr), 64'd8);
        check_pixels("t6");
        check("t6_words", 64'(widx), 64'd3);
        check("t6_done_once", 64'(ndone), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
